// File: rtl/cnnip_pkg.sv
// Shared types and default sizing for the CNN IP memory reader.
package cnnip_pkg;

    localparam int CNNIP_ADDR_WIDTH = 20;
    localparam int CNNIP_DATA_WIDTH = 32;
    localparam int CNNIP_LEN_WIDTH  = 16;
    localparam int CNNIP_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/cnnip_mem_if.sv
// Word-addressed read/write memory port; the reader only uses the read half.
interface cnnip_mem_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;

    modport master (output en, output we, output addr, output din,
                    input dout, input valid);
    modport slave  (input en, input we, input addr, input din,
                    output dout, output valid);
endinterface

// File: rtl/cnnip_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may coincide when full.
module cnnip_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // a push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem_q[rd_ptr];

    // storage write; data needs no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr] <= din;
        end
    end

    // pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cnnip_mem_reader.sv
// Streams len consecutive memory words starting at base_addr out of a
// valid/ready port. Reads are only issued when the FIFO has guaranteed room
// for every in-flight word, so any fixed read latency is safe.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for start
// ST_READ  | issuing reads while credit allows
// ST_DRAIN | all reads issued, waiting for last word to leave
// ST_DONE  | single cycle, raises done on the following cycle
module cnnip_mem_reader
    import cnnip_pkg::*;
#(
    parameter int ADDR_WIDTH = CNNIP_ADDR_WIDTH,
    parameter int DATA_WIDTH = CNNIP_DATA_WIDTH,
    parameter int LEN_WIDTH  = CNNIP_LEN_WIDTH,
    parameter int FIFO_DEPTH = CNNIP_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    cnnip_mem_if.master           mem,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    rd_state_t             state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [OW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           inflight;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // credit = words in flight plus words buffered; never exceed the buffer
    assign inflight = (CW+1)'(outstanding) + (CW+1)'(fifo_count);
    assign issue    = (state == ST_READ) && (remaining != '0) && !fifo_full &&
                      (inflight < (CW+1)'(FIFO_DEPTH));
    // stray returns (e.g. from a transfer killed by reset) carry no credit
    assign push     = mem.valid && (outstanding != '0);
    assign pop      = m_valid && m_ready;
    assign m_valid  = !fifo_empty;

    assign mem.en   = issue;
    assign mem.addr = addr_q;
    assign mem.we   = 1'b0;
    assign mem.din  = '0;

    // count reads whose data has not yet come back
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
        end else begin
            case ({issue, push})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // transfer sequencing with registered busy/done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_q    <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        state     <= (len == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((outstanding == '0) &&
                        (fifo_empty || ((fifo_count == CW'(1)) && pop))) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cnnip_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (mem.dout),
        .pop   (pop),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_cnnip_mem_reader.sv
// Directed bench for cnnip_mem_reader with a fixed-latency memory model.
module tb_cnnip_mem_reader;
    import cnnip_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int FD = 4;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len       = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    cnnip_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    cnnip_mem_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem       (mem),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {12'hA5C, a};
    endfunction

    // fixed-latency memory: data for a read issued in cycle k is valid in cycle k+lat
    int            lat = 1;
    logic          v_pipe [8] = '{default: 1'b0};
    logic [AW-1:0] a_pipe [8] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) begin
            v_pipe[i] <= v_pipe[i-1];
            a_pipe[i] <= a_pipe[i-1];
        end
        v_pipe[0] <= mem.en;
        a_pipe[0] <= mem.addr;
    end
    assign mem.valid = v_pipe[lat-1];
    assign mem.dout  = v_pipe[lat-1] ? mdata(a_pipe[lat-1]) : 32'hDEAD_BEEF;

    // monitor: log issued addresses, accepted words, done pulses, stall stability
    int            cyc = 0;
    logic [AW-1:0] aq [$];
    int            icyc [$];
    logic [DW-1:0] dq [$];
    int            done_cnt  = 0;
    int            stall_err = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem.en === 1'b1) begin
            aq.push_back(mem.addr);
            icyc.push_back(cyc);
        end
        if (m_valid && m_ready) dq.push_back(m_data);
        if (done === 1'b1) done_cnt++;
        if (stall_prev && (m_valid !== 1'b1 || m_data !== hold_data)) stall_err++;
        stall_prev = (m_valid === 1'b1) && !m_ready;
        hold_data  = m_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        aq.delete();
        icyc.delete();
        dq.delete();
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input logic [LW-1:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(done === 1'b1), 64'd1);
    endtask

    task automatic chk_addrs(input string tag, input logic [AW-1:0] b, input int n);
        logic [AW-1:0] e;
        chk({tag, "_count"}, 64'(aq.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            e = b + AW'(i);
            chk(tag, (i < aq.size()) ? 64'(aq[i]) : 64'hFFFF_FFFF, 64'(e));
        end
    endtask

    task automatic chk_words(input string tag, input logic [AW-1:0] b, input int n);
        logic [AW-1:0] e;
        chk({tag, "_count"}, 64'(dq.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            e = b + AW'(i);
            chk(tag, (i < dq.size()) ? 64'(dq[i]) : 64'hFFFF_FFFF_FFFF, 64'(mdata(e)));
        end
    endtask

    initial begin
        int d0;
        int n;
        logic saw_valid;

        // reset state
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_mem_en",  64'(mem.en),  64'd0);
        chk("rst_mem_we",  64'(mem.we),  64'd0);
        chk("rst_mem_din", 64'(mem.din), 64'd0);
        rstn = 1'b1;
        repeat (2) tick();

        // len=8 at 0x10, latency 1, always ready: back-to-back reads
        lat = 1; m_ready = 1'b1; clear_logs(); d0 = done_cnt;
        start_xfer(20'h00010, 16'd8);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        wait_done("t1_done_seen", 100);
        chk("t1_busy_at_done", 64'(busy), 64'd0);
        repeat (3) tick();
        chk_addrs("t1_addr", 20'h00010, 8);
        chk_words("t1_data", 20'h00010, 8);
        chk("t1_back_to_back", (icyc.size() == 8) ? 64'(icyc[7] - icyc[0]) : 64'hFFFF, 64'd7);
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t1_we_low", 64'(mem.we), 64'd0);

        // len=0: busy exactly one cycle, done two cycles after start
        clear_logs();
        start_xfer(20'h00055, 16'd0);
        chk("t2_busy_c1", 64'(busy), 64'd1);
        chk("t2_done_c1", 64'(done), 64'd0);
        tick();
        chk("t2_busy_c2", 64'(busy), 64'd0);
        chk("t2_done_c2", 64'(done), 64'd1);
        tick();
        chk("t2_done_c3", 64'(done), 64'd0);
        chk("t2_no_reads", 64'(aq.size()), 64'd0);

        // len=16, latency 3, downstream stalled 20 cycles: only FIFO_DEPTH reads
        lat = 3; m_ready = 1'b0; clear_logs(); stall_err = 0; d0 = done_cnt;
        start_xfer(20'h00200, 16'd16);
        repeat (19) tick();
        chk("t3_stall_reads", 64'(aq.size()), 64'(FD));
        chk("t3_stall_valid", 64'(m_valid), 64'd1);
        chk("t3_stall_head", 64'(m_data), 64'(mdata(20'h00200)));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_start_ignored_reads", 64'(aq.size()), 64'(FD));
        m_ready = 1'b1;
        wait_done("t3_done_seen", 300);
        repeat (3) tick();
        chk_addrs("t3_addr", 20'h00200, 16);
        chk_words("t3_data", 20'h00200, 16);
        chk("t3_stall_stable", 64'(stall_err), 64'd0);
        chk("t3_done_pulses", 64'(done_cnt - d0), 64'd1);

        // address wrap at the top of the address space
        lat = 1; m_ready = 1'b1; clear_logs();
        start_xfer(20'hFFFFE, 16'd4);
        wait_done("t4_done_seen", 100);
        repeat (3) tick();
        chk_addrs("t4_addr", 20'hFFFFE, 4);
        chk_words("t4_data", 20'hFFFFE, 4);

        // ready toggling every cycle, latency 2
        lat = 2; m_ready = 1'b1; clear_logs(); stall_err = 0;
        start_xfer(20'h00040, 16'd10);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            m_ready = ~m_ready;
            tick();
            n++;
        end
        chk("t5_done_seen", 64'(done === 1'b1), 64'd1);
        m_ready = 1'b1;
        repeat (3) tick();
        chk_words("t5_data", 20'h00040, 10);
        chk("t5_stall_stable", 64'(stall_err), 64'd0);

        // reset after three words of a len=8 transfer, then a fresh len=2 transfer
        lat = 3; m_ready = 1'b1; clear_logs(); d0 = done_cnt;
        start_xfer(20'h00100, 16'd8);
        n = 0;
        while (dq.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_three_words", 64'(dq.size() >= 3), 64'd1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_busy",    64'(busy),    64'd0);
        chk("t6_rst_m_valid", 64'(m_valid), 64'd0);
        chk("t6_rst_mem_en",  64'(mem.en),  64'd0);
        tick();
        rstn = 1'b1;
        clear_logs();
        saw_valid = 1'b0;
        repeat (6) begin
            tick();
            if (m_valid !== 1'b0) saw_valid = 1'b1;
        end
        chk("t6_stale_discarded", 64'(saw_valid), 64'd0);
        start_xfer(20'h00300, 16'd2);
        wait_done("t6_done_seen", 100);
        repeat (3) tick();
        chk_words("t6_data", 20'h00300, 2);
        chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
